// File: rtl/serial_tx_shifter.sv
// Parallel-to-serial transmitter with a one-word holding buffer.
// Words stream back-to-back with no idle gap. frame_start marks the first bit of each word.
module serial_tx_shifter #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic             ser_out_q, ser_out_d;
  logic             ser_valid_q, ser_valid_d;
  logic             frame_start_q, frame_start_d;
  logic             busy_q, busy_d;
  logic             xfer;

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  assign in_ready = !hold_full_q;
  assign xfer     = in_valid && !hold_full_q;

  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    cnt_d         = cnt_q;
    hold_d        = hold_q;
    hold_full_d   = hold_full_q;
    frame_start_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          shift_d       = in_data;
          cnt_d         = '0;
          state_d       = SHIFT;
          frame_start_d = 1'b1;
        end
      end
      SHIFT: begin
        if (cnt_q == LAST) begin
          // A buffered word always wins; in_ready is low then, so no transfer can collide with it.
          if (hold_full_q) begin
            shift_d       = hold_q;
            hold_full_d   = 1'b0;
            cnt_d         = '0;
            frame_start_d = 1'b1;
          end else if (xfer) begin
            shift_d       = in_data;
            cnt_d         = '0;
            frame_start_d = 1'b1;
          end else begin
            shift_d = '0;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end else begin
          shift_d = advance(shift_q);
          cnt_d   = cnt_q + 1'b1;
          if (xfer) begin
            hold_d      = in_data;
            hold_full_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Outputs are computed from next state so they reflect the bit being shifted during the coming cycle.
    ser_valid_d = (state_d == SHIFT);
    ser_out_d   = (state_d == SHIFT) && first_bit(shift_d);
    busy_d      = (state_d == SHIFT) || hold_full_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      shift_q       <= '0;
      cnt_q         <= '0;
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      ser_out_q     <= 1'b0;
      ser_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      cnt_q         <= cnt_d;
      hold_q        <= hold_d;
      hold_full_q   <= hold_full_d;
      ser_out_q     <= ser_out_d;
      ser_valid_q   <= ser_valid_d;
      frame_start_q <= frame_start_d;
      busy_q        <= busy_d;
    end
  end

  assign ser_out     = ser_out_q;
  assign ser_valid   = ser_valid_q;
  assign frame_start = frame_start_q;
  assign busy        = busy_q;

endmodule

// File: doc/serial_tx_shifter.md
SERIAL_TX_SHIFTER -- requirements
Module: serial_tx_shifter

Interface
REQ-001 Parameter WIDTH, default 8; word length in bits; legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1; 1 = word bit WIDTH-1 transmitted first, 0 = bit 0 first.
REQ-003 Port clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port in_valid  input  1  producer offers in_data this cycle.
REQ-006 Port in_data  input  WIDTH  parallel word to serialize.
REQ-007 Port in_ready  output  1  block can accept a word this cycle.
REQ-008 Port ser_out  output  1  current serial bit.
REQ-009 Port ser_valid  output  1  ser_out carries a valid bit this cycle.
REQ-010 Port frame_start  output  1  high only while the first bit of a word is on ser_out.
REQ-011 Port busy  output  1  high while shifting or while the holding buffer is full.

Function
REQ-012 Storage SHALL be: shift register (WIDTH bits), bit counter (ceil(log2(WIDTH)) bits), one-entry holding buffer (WIDTH bits plus full flag).
REQ-013 States SHALL be IDLE (shift register empty) and SHIFT (shift register active).
REQ-014 A transfer SHALL occur on a rising edge where in_valid and in_ready are both 1.
REQ-015 in_ready SHALL be combinational and equal to NOT hold_full; it does not depend on in_valid.
REQ-016 In IDLE, a transfer SHALL load in_data into the shift register, clear the counter, and enter SHIFT; the holding buffer stays empty.
REQ-017 In SHIFT, a transfer SHALL load the holding buffer, except in the last-bit cycle when the buffer is empty (see REQ-020).
REQ-018 All outputs except in_ready SHALL be registered; the first bit appears on ser_out the cycle after acceptance (latency 1).
REQ-019 In SHIFT, ser_valid = 1 each cycle; counter increments each edge; bits go out in the order set by MSB_FIRST, one per cycle, WIDTH cycles per word.
REQ-020 Last-bit cycle (counter = WIDTH-1), next edge:
- buffer full: load buffer into shift register, clear buffer, stay in SHIFT.
- else, transfer present: load in_data directly, stay in SHIFT.
- else: go to IDLE.
REQ-021 Back-to-back words SHALL have no idle gap; frame_start SHALL pulse for one cycle on the first bit of each word.
REQ-022 In IDLE: ser_valid = 0, frame_start = 0, ser_out = 0.
REQ-023 busy SHALL be 1 in SHIFT or whenever hold_full = 1.
REQ-024 in_data SHALL be ignored when no transfer occurs; a word with in_valid held high is accepted exactly once per transfer.

Reset
REQ-025 While rst_n = 0: state IDLE, counter 0, shift register 0, hold_full 0, ser_out 0, ser_valid 0, frame_start 0, busy 0.
REQ-026 Assertion mid-word SHALL abort immediately without waiting for clk; partial and buffered words are discarded.
REQ-027 After rst_n deasserts, in_ready SHALL be 1 and the first transfer is accepted on the next rising edge.

Verification
REQ-028 WIDTH=8, MSB_FIRST=1, send 0xA5 once -> ser_out 1,0,1,0,0,1,0,1 on cycles 1..8; frame_start only on cycle 1; ser_valid 0 on cycle 9.
REQ-029 MSB_FIRST=0, send 0xA5 -> ser_out 1,0,1,0,0,1,0,1 (LSB first); busy 1 on cycles 1..8, 0 afterwards.
REQ-030 Send 0x3C then 0xFF with in_valid held high -> 0x3C accepted at cycle 0, 0xFF into buffer at cycle 1, in_ready 0 until buffer drains; 16 contiguous valid bits; frame_start on cycles 1 and 9.
REQ-031 Present 0x81 exactly in the last-bit cycle of 0x00 with buffer empty -> accepted, 0x81 starts the next cycle with no gap.
REQ-032 Pull rst_n low between clock edges at bit 4 with buffer full -> all outputs 0 immediately; after release, in_ready 1; no further bits of either word appear.
REQ-033 in_valid = 0 for 20 cycles after reset -> ser_valid, frame_start, busy stay 0; in_ready stays 1.
